// File: rtl/cpu_run_ctrl_if.sv
// Debug command handshake between the debug port and the run controller.
interface cpu_run_ctrl_if #(
  parameter int unsigned STEP_WIDTH = 8
);
  localparam int unsigned OP_W = 2;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [STEP_WIDTH-1:0] cmd_arg;

  // Debug side issues commands.
  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  // Controller side accepts commands.
  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: gates the core PC enable, pulses the core
// reset and stops execution on an instruction-address breakpoint.
module cpu_run_ctrl #(
  parameter int unsigned INSTR_ADDR_WIDTH = 4,
  parameter int unsigned STEP_WIDTH       = 8,
  parameter int unsigned RST_CYCLES       = 2
) (
  input  logic                        clk,
  input  logic                        n_reset,
  cpu_run_ctrl_if.slave               cmd,
  input  logic                        bp_en,
  input  logic [INSTR_ADDR_WIDTH-1:0] bp_addr,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc_count,
  input  logic                        core_pc_en,
  output logic                        run_en,
  output logic                        cpu_n_reset,
  output logic [1:0]                  state,
  output logic                        bp_hit,
  output logic [STEP_WIDTH-1:0]       steps_left
);

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES);

  localparam logic [OP_W-1:0] OP_RUN   = 2'b00;
  localparam logic [OP_W-1:0] OP_HALT  = 2'b01;
  localparam logic [OP_W-1:0] OP_STEP  = 2'b10;
  localparam logic [OP_W-1:0] OP_RESET = 2'b11;

  typedef enum logic [1:0] {
    ST_HALT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STEP     = 2'b10,
    ST_CORE_RST = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic                  skip_q, skip_d;
  logic                  hit_q, hit_d;
  logic                  nrst_q, nrst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic bp_match;
  logic accept;
  logic advance;

  // Breakpoint compare is suppressed until the first advance after a resume.
  assign bp_match      = bp_en & (pc_count == bp_addr) & ~skip_q;
  assign run_en        = ((state_q == ST_RUN) & ~bp_match) | (state_q == ST_STEP);
  assign cmd.cmd_ready = (state_q == ST_HALT) | (state_q == ST_RUN);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign advance       = run_en & core_pc_en;

  assign state       = state_q;
  assign steps_left  = steps_q;
  assign bp_hit      = hit_q;
  assign cpu_n_reset = nrst_q;

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_HALT;
      steps_q <= '0;
      skip_q  <= 1'b0;
      hit_q   <= 1'b0;
      nrst_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      skip_q  <= skip_d;
      hit_q   <= hit_d;
      nrst_q  <= nrst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    skip_d  = skip_q;
    hit_d   = 1'b0;
    nrst_d  = 1'b1;
    cnt_d   = cnt_q;

    if (advance) begin
      skip_d = 1'b0;
    end

    unique case (state_q)
      ST_HALT: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              skip_d  = 1'b1;
            end
            OP_STEP: begin
              if (cmd.cmd_arg != '0) begin
                state_d = ST_STEP;
                steps_d = cmd.cmd_arg;
                skip_d  = 1'b1;
              end
            end
            OP_RESET: begin
              state_d = ST_CORE_RST;
              cnt_d   = '0;
              skip_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (accept && (cmd.cmd_op == OP_RESET)) begin
          state_d = ST_CORE_RST;
          cnt_d   = '0;
          skip_d  = 1'b0;
        end else if ((accept && (cmd.cmd_op == OP_HALT)) || bp_match) begin
          state_d = ST_HALT;
          hit_d   = bp_match;
        end
      end

      ST_STEP: begin
        if (advance) begin
          steps_d = steps_q - STEP_WIDTH'(1);
          if (steps_q == STEP_WIDTH'(1)) begin
            state_d = ST_HALT;
          end
        end
      end

      ST_CORE_RST: begin
        steps_d = '0;
        skip_d  = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          nrst_d = 1'b0;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized commands, checked
// every cycle against an edge-numbered behavioural model.
module tb_cpu_run_ctrl;
  localparam int unsigned AW   = 4;
  localparam int unsigned SW   = 8;
  localparam int unsigned RSTC = 2;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          bp_en;
  logic [AW-1:0] bp_addr;
  logic [AW-1:0] pc;
  logic          core_pc_en;
  logic          run_en;
  logic          cpu_n_reset;
  logic [1:0]    state;
  logic          bp_hit;
  logic [SW-1:0] steps_left;

  cpu_run_ctrl_if #(.STEP_WIDTH(SW)) cmd_if ();

  cpu_run_ctrl #(
    .INSTR_ADDR_WIDTH(AW),
    .STEP_WIDTH(SW),
    .RST_CYCLES(RSTC)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .cmd(cmd_if),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc_count(pc),
    .core_pc_en(core_pc_en),
    .run_en(run_en),
    .cpu_n_reset(cpu_n_reset),
    .state(state),
    .bp_hit(bp_hit),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 HALT, 1 RUN, 2 STEP, 3 CORE_RST; reset window tracked by edge number.
  int m_mode;
  int m_steps;
  bit m_skip;
  bit m_hit;
  bit m_nrst;
  int edge_no = 0;
  int m_release;

  task automatic check1(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d edge=%0d", name, act, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_steps = 0;
    m_skip  = 1'b0;
    m_hit   = 1'b0;
    m_nrst  = 1'b0;
  endtask

  function automatic bit m_match();
    return bp_en && (pc == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_run();
    return (m_mode == 1 && !m_match()) || (m_mode == 2);
  endfunction

  task automatic compare_all();
    check1("state", state, m_mode);
    check1("run_en", run_en, m_run());
    check1("cmd_ready", cmd_if.cmd_ready, (m_mode <= 1));
    check1("cpu_n_reset", cpu_n_reset, m_nrst);
    check1("bp_hit", bp_hit, m_hit);
    check1("steps_left", steps_left, m_steps);
  endtask

  // Apply the rules for one rising edge using the inputs held before it.
  task automatic model_edge(output bit adv);
    bit acc, match;
    int op;
    adv = 1'b0;
    if (!n_reset) return;
    edge_no++;
    match = m_match();
    acc   = cmd_if.cmd_valid && (m_mode <= 1);
    op    = int'(cmd_if.cmd_op);
    adv   = m_run() && core_pc_en;
    m_hit  = 1'b0;
    m_nrst = 1'b1;
    if (adv) m_skip = 1'b0;
    case (m_mode)
      0: if (acc) begin
        if (op == 0) begin m_mode = 1; m_skip = 1'b1; end
        else if (op == 2 && cmd_if.cmd_arg != 0) begin
          m_mode = 2; m_steps = int'(cmd_if.cmd_arg); m_skip = 1'b1;
        end else if (op == 3) begin m_mode = 3; m_release = edge_no + RSTC + 1; end
      end
      1: begin
        if (acc && op == 3) begin m_mode = 3; m_release = edge_no + RSTC + 1; end
        else if ((acc && op == 1) || match) begin m_mode = 0; m_hit = match; end
      end
      2: if (adv) begin
        m_steps--;
        if (m_steps == 0) m_mode = 0;
      end
      default: begin
        m_skip  = 1'b0;
        m_steps = 0;
        if (edge_no == m_release) m_mode = 0;
        else m_nrst = 1'b0;
      end
    endcase
  endtask

  // One clock: compare mid-cycle, take the edge, advance the core PC just after it.
  task automatic cycle();
    bit adv;
    #1;
    compare_all();
    @(posedge clk);
    model_edge(adv);
    #1;
    if (adv) pc = pc + 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [SW-1:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    cycle();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Assert n_reset between edges and check outputs before any edge.
  task automatic async_rst();
    #2;
    n_reset = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  int  hits;
  int  step_cycles;
  int  nlow;
  bit  wrapped;
  bit  ready_bad;
  bit  found;

  initial begin
    n_reset          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_arg   = '0;
    bp_en            = 1'b0;
    bp_addr          = '0;
    pc               = '0;
    core_pc_en       = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    cycle();

    // Reset release.
    n_reset = 1'b1;
    cycle();
    check1("rst_state", state, 0);
    check1("rst_ready", cmd_if.cmd_ready, 1);
    check1("rst_run_en", run_en, 0);
    check1("rst_nrst_rise", cpu_n_reset, 1);

    // Run into breakpoint at 5.
    bp_en = 1'b1; bp_addr = 4'd5; core_pc_en = 1'b1;
    send(2'b00, '0);
    hits = 0;
    repeat (12) begin cycle(); hits += int'(bp_hit); end
    check1("bp_stop_pc", pc, 5);
    check1("bp_hit_count", hits, 1);
    check1("bp_halt_state", state, 0);

    // Resume from the breakpoint: no re-hit, PC wraps.
    send(2'b00, '0);
    hits = 0; wrapped = 1'b0;
    for (int i = 0; i < 20 && !wrapped; i++) begin
      cycle();
      hits += int'(bp_hit);
      if (pc == 0) wrapped = 1'b1;
    end
    check1("resume_wrap", wrapped, 1);
    check1("resume_no_hit", hits, 0);
    send(2'b01, '0);
    check1("halt_cmd", state, 0);

    // STEP 3 from PC 2 with a two-cycle stall; breakpoint on the path is ignored.
    pc = 4'd2; bp_addr = 4'd3;
    send(2'b10, 8'd3);
    step_cycles = 0; ready_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      core_pc_en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      #1;
      if (state == 2'b10) begin
        step_cycles++;
        if (cmd_if.cmd_ready !== 1'b0) ready_bad = 1'b1;
      end
      cycle();
    end
    core_pc_en = 1'b1;
    check1("step_pc", pc, 5);
    check1("step_cycles", step_cycles, 5);
    check1("step_ready_low", ready_bad, 0);
    check1("step_done_state", state, 0);

    // STEP 0 is a no-op.
    send(2'b10, 8'd0);
    check1("step0_state", state, 0);
    check1("step0_run_en", run_en, 0);

    // RESET while running.
    bp_en = 1'b0;
    send(2'b00, '0);
    repeat (3) cycle();
    send(2'b11, '0);
    nlow = 0;
    repeat (8) begin
      if (!cpu_n_reset) nlow++;
      cycle();
    end
    check1("rst_low_cycles", nlow, 2);
    check1("rst_done_state", state, 0);
    check1("rst_steps", steps_left, 0);

    // RESET coinciding with a breakpoint match.
    bp_en = 1'b1; bp_addr = pc + 4'd3;
    send(2'b00, '0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (state == 2'b01 && pc == bp_addr) found = 1'b1;
      else cycle();
    end
    check1("bprst_found", found, 1);
    send(2'b11, '0);
    check1("bprst_state", state, 3);
    check1("bprst_hit", bp_hit, 0);
    repeat (4) cycle();

    // Asynchronous reset in the middle of a STEP.
    bp_en = 1'b0;
    send(2'b10, 8'd6);
    cycle();
    cycle();
    check1("step4_left", steps_left, 4);
    async_rst();
    check1("arst_state", state, 0);
    check1("arst_run_en", run_en, 0);
    check1("arst_ready", cmd_if.cmd_ready, 1);
    check1("arst_nrst", cpu_n_reset, 0);
    check1("arst_hit", bp_hit, 0);
    check1("arst_steps", steps_left, 0);
    cycle();
    n_reset = 1'b1;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cmd_if.cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_if.cmd_op    = 2'($urandom_range(0, 3));
      cmd_if.cmd_arg   = 8'($urandom_range(0, 5));
      bp_en            = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) bp_addr = 4'($urandom_range(0, 15));
      core_pc_en       = ($urandom_range(0, 3) != 0);
      if (!cpu_n_reset) pc = '0;
      if ($urandom_range(0, 199) == 0) begin
        async_rst();
        cycle();
        n_reset = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller that sequences the CPU core from a debug command port. It gates the program-counter enable, can pulse the core reset and stops execution at a hardware breakpoint on the instruction address. It sits between the debug interface and the core. Its `run_en` output is ANDed into the core's PC enable, and its `cpu_n_reset` output drives the core's `n_reset`.

## Interface
Parameters:
- INSTR_ADDR_WIDTH, 4: width of the PC and the breakpoint address.
- STEP_WIDTH, 8: width of the step count and `steps_left`.
- RST_CYCLES, 2: number of cycles `cpu_n_reset` is held low by a RESET command (≥1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 RESET.
- cmd_arg  in  STEP_WIDTH  step count; used only by STEP.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  INSTR_ADDR_WIDTH  breakpoint instruction address.
- pc_count  in  INSTR_ADDR_WIDTH  core's current PC.
- core_pc_en  in  1  core's own PC enable (0 while the core executes a wait instruction).
- run_en  out  1  PC gate to the core.
- cpu_n_reset  out  1  registered, active-low reset to the core.
- state  out  2  00 HALT, 01 RUN, 10 STEP, 11 CORE_RST.
- bp_hit  out  1  registered one-cycle pulse when a breakpoint halts execution.
- steps_left  out  STEP_WIDTH  steps remaining in STEP.

## Operation
Definitions:
- Accept = cmd_valid & cmd_ready at a rising edge.
- Advance = run_en & core_pc_en at a rising edge (the PC increments).

Combinational outputs:
- cmd_ready = 1 in HALT or RUN; 0 in STEP or CORE_RST.
- bp_match = bp_en & (pc_count == bp_addr) & ~bp_skip.
- run_en = (state==RUN & ~bp_match) | (state==STEP).

HALT state:
- RUN → RUN; set bp_skip.
- STEP with arg N≠0 → STEP; steps_left=N; set bp_skip.
- STEP with arg 0 → no effect; the command is still accepted.
- HALT → no effect.
- RESET → CORE_RST.

RUN state:
- HALT → HALT.
- RESET → CORE_RST.
- STEP, RUN → no effect.
- If bp_match and no RESET is accepted → HALT, and bp_hit pulses.
- An accepted HALT coinciding with bp_match → HALT, and bp_hit pulses.
- An accepted RESET coinciding with bp_match → CORE_RST; bp_hit stays 0.

STEP state:
- Breakpoints are ignored.
- Each Advance decrements steps_left.
- An Advance with steps_left==1 → HALT, steps_left=0.
- Cycles with core_pc_en=0 (core waiting) do not decrement.

CORE_RST state:
- cpu_n_reset = 0 for exactly RST_CYCLES cycles, then → HALT.
- bp_skip and steps_left are cleared.

bp_skip:
- Cleared on the first Advance after being set.
- This lets execution resume from a breakpoint address without re-triggering.

## Timing
Values held during n_reset low:
- state=HALT, run_en=0, cmd_ready=1, bp_hit=0, steps_left=0, bp_skip=0.
- cpu_n_reset=0, internal reset counter cleared.
- cpu_n_reset rises at the first rising edge after n_reset deasserts.

Command latency:
- A command accepted at edge k changes `state` at edge k.
- run_en reflects the new state in cycle k+1 (the cycle after edge k).

Breakpoint stop:
- run_en drops in the same cycle that bp_match rises, so the instruction at bp_addr does not advance.
- state=HALT from the next edge; bp_hit is high for that one cycle.

RESET command:
- Accepted at edge k → cpu_n_reset low from edge k+1 through edge k+RST_CYCLES.
- state=HALT and cpu_n_reset=1 from edge k+RST_CYCLES+1.

STEP with N:
- Completes after exactly N Advance edges.
- Wall-clock time is N plus the number of stall cycles.

Asynchronous reset mid-operation:
- Immediately forces every value listed above, from any state.

## Test plan
- Reset: release n_reset → state=00, run_en=0, cmd_ready=1, cpu_n_reset=1 one edge later.
- RUN with bp_en=1, bp_addr=5, core_pc_en=1 → PC advances 0..5 and stops at 5; bp_hit pulses once; state=HALT. Then RUN → PC advances to 6 with no re-hit, and wraps 15→0.
- STEP arg=3 from PC=2, core_pc_en low for 2 cycles mid-step → exactly 3 advances; HALT at PC=5; cmd_ready=0 throughout and STEP duration 5 cycles.
- STEP arg=0 → accepted; state stays HALT; run_en stays 0.
- RESET while running with RST_CYCLES=2 → cpu_n_reset low for exactly 2 cycles; then HALT with steps_left=0. RESET issued in the same cycle as bp_match → CORE_RST, bp_hit=0.
- Assert n_reset low during STEP with steps_left=4 → all outputs return to their reset values asynchronously, with no clock edge needed.
